pc_update_unit: RTL and testbench

- Owns the architectural PC and EPC registers of the multicycle MIPS core.
- Sits directly downstream of the PC-source multiplexer and consumes its 32-bit next-PC value.
- Decides when PC is written: unconditional write, or conditional write resolved from the ALU branch flags.
- Runs a small exception-entry sequencer: saves EPC, fetches the handler byte from memory, loads it into PC.

---
 rtl/pc_update_pkg.sv | 48 ++++
 rtl/pc_update_unit_branch_cond_eval.sv | 30 +++
 rtl/pc_update_unit.sv | 142 ++++++++++++++
 tb/tb_pc_update_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_update_pkg.sv
// -----------------------------------------------------------------------------
// pc_update_pkg
// Shared definitions for the PC update unit of the multicycle MIPS core:
//   - branch condition encodings carried on BranchOp
//   - exception type encodings carried on ExcpType
//   - exception-entry sequencer states
//   - default memory address of the first exception handler byte
// -----------------------------------------------------------------------------
package pc_update_pkg;

    // Branch condition selected by the control unit for PCWriteCond.
    typedef enum logic [1:0] {
        BR_EQ = 2'b00,  // beq : taken when Zero
        BR_NE = 2'b01,  // bne : taken when !Zero
        BR_LE = 2'b10,  // ble : taken when Zero | !Gt
        BR_GT = 2'b11   // bgt : taken when Gt
    } branch_op_e;

    // Exception causes. Encoding 3 is reserved and folded onto EXC_DIV0.
    typedef enum logic [1:0] {
        EXC_OPCODE = 2'd0,
        EXC_OVF    = 2'd1,
        EXC_DIV0   = 2'd2
    } exc_type_e;

    // Exception-entry sequencer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAVE = 2'd1,
        S_READ = 2'd2,
        S_LOAD = 2'd3
    } excp_state_e;

    // Handler byte for exception type n lives at DEFAULT_EXC_BASE + n.
    localparam logic [31:0] DEFAULT_EXC_BASE = 32'd253;

    // Map the raw 2-bit cause onto a legal exception type.
    function automatic exc_type_e fold_exc_type(input logic [1:0] raw);
        exc_type_e t;
        unique case (raw)
            2'd0:    t = EXC_OPCODE;
            2'd1:    t = EXC_OVF;
            default: t = EXC_DIV0;
        endcase
        return t;
    endfunction

endpackage : pc_update_pkg

// File: rtl/pc_update_unit_branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational evaluation of the branch condition from the ALU flags.
// Ports:
//   i_branch_op  in  2  branch condition select (BR_EQ/BR_NE/BR_LE/BR_GT)
//   i_zero       in  1  ALU zero flag
//   i_gt         in  1  ALU A>B flag
//   o_cond       out 1  condition is true
// -----------------------------------------------------------------------------
module branch_cond_eval
    import pc_update_pkg::*;
(
    input  logic [1:0] i_branch_op,
    input  logic       i_zero,
    input  logic       i_gt,
    output logic       o_cond
);

    always_comb begin
        o_cond = 1'b0;
        unique case (branch_op_e'(i_branch_op))
            BR_EQ:   o_cond = i_zero;
            BR_NE:   o_cond = ~i_zero;
            BR_LE:   o_cond = i_zero | ~i_gt;
            BR_GT:   o_cond = i_gt;
            default: o_cond = 1'b0;
        endcase
    end

endmodule : branch_cond_eval

// File: rtl/pc_update_unit.sv
// -----------------------------------------------------------------------------
// pc_update_unit
// Owns the architectural PC and EPC of the multicycle MIPS core. Writes PC from
// the PC-source mux on an unconditional strobe or on a taken branch, and runs
// the exception-entry sequence: save EPC, fetch the handler byte, load PC.
//
// Parameters:
//   RESET_PC   PC value after reset
//   EXC_BASE   address of the handler byte for exception type 0 (type n: +n)
//   MEM_LAT    cycles from ExcpMemRead asserted to MemExcpByte valid (1..7)
//
// Ports:
//   clk          in  1   core clock, rising edge
//   reset        in  1   asynchronous active-low reset
//   PCWrite      in  1   unconditional PC write strobe
//   PCWriteCond  in  1   conditional (branch) PC write strobe
//   BranchOp     in  2   branch condition select
//   Zero         in  1   ALU zero flag
//   Gt           in  1   ALU A>B flag
//   MuxPCSrcOut  in  32  next-PC value
//   ExcpReq      in  1   exception request pulse
//   ExcpType     in  2   exception cause (3 treated as 2)
//   MemExcpByte  in  8   handler byte returned by memory
//   PCOut        out 32  current PC
//   EPCOut       out 32  exception PC
//   ExcpMemAddr  out 32  handler byte address
//   ExcpMemRead  out 1   handler byte read request
//   ExcpBusy     out 1   sequencer active; control unit stalls
// -----------------------------------------------------------------------------
module pc_update_unit
    import pc_update_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_BASE = DEFAULT_EXC_BASE,
    parameter int unsigned MEM_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [1:0]  BranchOp,
    input  logic        Zero,
    input  logic        Gt,
    input  logic [31:0] MuxPCSrcOut,
    input  logic        ExcpReq,
    input  logic [1:0]  ExcpType,
    input  logic [7:0]  MemExcpByte,
    output logic [31:0] PCOut,
    output logic [31:0] EPCOut,
    output logic [31:0] ExcpMemAddr,
    output logic        ExcpMemRead,
    output logic        ExcpBusy
);

    // Last value of the READ wait counter before moving on to LOAD.
    localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

    excp_state_e r_state;
    excp_state_e w_next_state;
    exc_type_e   r_type;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [31:0] r_addr;
    logic [2:0]  r_cnt;
    logic        w_cond;
    logic        w_take;
    logic        w_cnt_done;

    branch_cond_eval u_branch_cond_eval (
        .i_branch_op (BranchOp),
        .i_zero      (Zero),
        .i_gt        (Gt),
        .o_cond      (w_cond)
    );

    // PCWrite forces the write regardless of the branch outcome.
    assign w_take     = PCWrite | (PCWriteCond & w_cond);
    assign w_cnt_done = (r_cnt == CNT_LAST);

    // -------------------------------------------------------------------------
    // Sequencer next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (ExcpReq) w_next_state = S_SAVE;
            S_SAVE:  w_next_state = S_READ;
            S_READ:  if (w_cnt_done) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, PC, EPC, handler address and wait counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_type  <= EXC_OPCODE;
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                S_IDLE: begin
                    // An exception request takes priority over any PC write.
                    if (ExcpReq) begin
                        r_type <= fold_exc_type(ExcpType);
                    end else if (w_take) begin
                        r_pc <= MuxPCSrcOut;
                    end
                    r_cnt <= '0;
                end
                S_SAVE: begin
                    // PC was already advanced at fetch; EPC points at the
                    // faulting instruction (32-bit wrap is intended).
                    r_epc  <= r_pc - 32'd4;
                    r_addr <= EXC_BASE + 32'(r_type);
                end
                S_READ: begin
                    r_cnt <= w_cnt_done ? '0 : r_cnt + 3'd1;
                end
                S_LOAD: begin
                    r_pc <= {24'b0, MemExcpByte};
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign PCOut       = r_pc;
    assign EPCOut      = r_epc;
    assign ExcpMemAddr = r_addr;
    assign ExcpMemRead = (r_state == S_READ);
    assign ExcpBusy    = (r_state != S_IDLE);

endmodule : pc_update_unit

// File: tb/tb_pc_update_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_update_unit
// Scoreboard bench: the driver applies one input vector per cycle, advances a
// cycle-level reference model and pushes the expected outputs; a monitor pops
// and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_pc_update_unit;

    localparam int unsigned MEM_LAT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_BASE = 32'd253;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCWrite = 1'b0;
    logic        PCWriteCond = 1'b0;
    logic [1:0]  BranchOp = 2'b00;
    logic        Zero = 1'b0;
    logic        Gt = 1'b0;
    logic [31:0] MuxPCSrcOut = '0;
    logic        ExcpReq = 1'b0;
    logic [1:0]  ExcpType = 2'b00;
    logic [7:0]  MemExcpByte = 8'h00;
    logic [31:0] PCOut;
    logic [31:0] EPCOut;
    logic [31:0] ExcpMemAddr;
    logic        ExcpMemRead;
    logic        ExcpBusy;

    pc_update_unit #(
        .RESET_PC (RESET_PC),
        .EXC_BASE (EXC_BASE),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchOp    (BranchOp),
        .Zero        (Zero),
        .Gt          (Gt),
        .MuxPCSrcOut (MuxPCSrcOut),
        .ExcpReq     (ExcpReq),
        .ExcpType    (ExcpType),
        .MemExcpByte (MemExcpByte),
        .PCOut       (PCOut),
        .EPCOut      (EPCOut),
        .ExcpMemAddr (ExcpMemAddr),
        .ExcpMemRead (ExcpMemRead),
        .ExcpBusy    (ExcpBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] addr;
        logic        rd;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] mem [256];

    // Reference model: PC/EPC/address plus the number of cycles elapsed since
    // an exception was accepted (-1 when none is in progress).
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_addr;
    int          m_phase;
    logic [1:0]  m_type;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [1:0] bop, input logic z, input logic g);
        case (bop)
            2'd0:    return z;
            2'd1:    return !z;
            2'd2:    return z || !g;
            default: return g;
        endcase
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_epc   = '0;
        m_addr  = '0;
        m_phase = -1;
        m_type  = 2'd0;
    endtask

    // One clock of stimulus plus the model's prediction for after the edge.
    task automatic step(input logic pw, input logic pwc, input logic [1:0] bop,
                        input logic z, input logic g, input logic [31:0] mux,
                        input logic req, input logic [1:0] typ);
        exp_t e;
        @(negedge clk);
        PCWrite = pw; PCWriteCond = pwc; BranchOp = bop; Zero = z; Gt = g;
        MuxPCSrcOut = mux; ExcpReq = req; ExcpType = typ;
        if (m_phase < 0) begin
            if (req) begin
                m_phase = 0;
                m_type  = (typ == 2'd3) ? 2'd2 : typ;
            end else if (pw || (pwc && ref_cond(bop, z, g))) begin
                m_pc = mux;
            end
        end else begin
            m_phase++;
            if (m_phase == 1) begin
                m_epc  = m_pc - 32'd4;
                m_addr = EXC_BASE + 32'(m_type);
            end
            if (m_phase == int'(MEM_LAT) + 2) begin
                m_pc    = {24'h0, mem[m_addr[7:0]]};
                m_phase = -1;
            end
        end
        e.pc   = m_pc;
        e.epc  = m_epc;
        e.addr = m_addr;
        e.busy = (m_phase >= 0);
        e.rd   = (m_phase >= 1) && (m_phase <= int'(MEM_LAT));
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, $urandom, 1'b0, 2'b00);
    endtask

    task automatic load_pc(input logic [31:0] v);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, v, 1'b0, 2'b00);
    endtask

    // Drop reset away from the clock edge and check the asynchronous effect.
    task automatic reset_mid_cycle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", PCOut, RESET_PC);
        check("async_rst_epc", EPCOut, 32'h0);
        check("async_rst_addr", ExcpMemAddr, 32'h0);
        check("async_rst_rd", {31'h0, ExcpMemRead}, 32'h0);
        check("async_rst_busy", {31'h0, ExcpBusy}, 32'h0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc", PCOut, e.pc);
                check("epc", EPCOut, e.epc);
                check("addr", ExcpMemAddr, e.addr);
                check("memread", {31'h0, ExcpMemRead}, {31'h0, e.rd});
                check("busy", {31'h0, ExcpBusy}, {31'h0, e.busy});
            end
        end
    end

    // Memory: byte is junk for the first MEM_LAT-1 read cycles, then valid
    // and held until the next read starts.
    initial begin
        int rd_cnt = 0;
        forever begin
            @(negedge clk);
            if (!ExcpMemRead) begin
                rd_cnt = 0;
            end else begin
                rd_cnt++;
                if (rd_cnt == 1) MemExcpByte = 8'hEE;
                if (rd_cnt == int'(MEM_LAT)) MemExcpByte = mem[ExcpMemAddr[7:0]];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i] == 8'hEE) mem[i] = 8'hEF;
        end
        mem[254] = 8'h8C;
        model_reset();

        // Power-on reset values.
        #3;
        check("por_pc", PCOut, RESET_PC);
        check("por_epc", EPCOut, 32'h0);
        check("por_busy", {31'h0, ExcpBusy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unconditional write, then hold.
        load_pc(32'h0000_0040);
        idle(2);

        // Branch matrix.
        for (int b = 0; b < 4; b++) begin
            for (int zg = 0; zg < 4; zg++) begin
                load_pc(32'h0000_0200);
                step(1'b0, 1'b1, 2'(b), zg[1], zg[0], 32'h0000_0100, 1'b0, 2'b00);
            end
        end
        // PCWrite together with a false condition still writes.
        load_pc(32'h0000_0300);
        step(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0104, 1'b0, 2'b00);

        // Overflow exception with a second request dropped during READ.
        load_pc(32'h0000_0024);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0500, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 2'd2);
        idle(4);

        // Collision: exception beats PCWrite; reserved type 3 folds onto 2.
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0999, 1'b1, 2'd3);
        idle(6);

        // Reset during READ, then a type-0 exception from PC=0 (EPC wraps).
        load_pc(32'h0000_0080);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1);
        idle(2);
        reset_mid_cycle();
        idle(2);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) == 0), ($urandom_range(3) == 0), 2'($urandom),
                 1'($urandom), 1'($urandom), $urandom,
                 ($urandom_range(11) == 0), 2'($urandom));
        end
        idle(8);

        @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_update_unit
